ct_f_spsram_param_init: RTL and testbench
=========================================

// Module: ct_f_spsram_param_init
// PURPOSE
//  Parametrised single-port SRAM macro model for FPGA/sim builds; generic successor to the fixed-size
//  ct_f_spsram_NxW models. Adds a configurable read pipeline, bit-masked writes, a hardware
//  init-clear engine that zeroes every entry after reset, and a read-valid strobe. Sits under the
//  cache/TLB array wrappers; keeps the active-low CEN/GWEN/WEN macro interface.
// PARAMETERS
//  ADDR_WIDTH  8    address bits; DEPTH = 2**ADDR_WIDTH entries
//  DATA_WIDTH  144  bits per entry
//  READ_PIPE   0    0: Q valid 1 cycle after read; 1: extra output register, Q valid 2 cycles after
//  INIT_EN     1    1: clear all entries after reset; 0: skip init, ready 1 cycle after reset
// PORTS
//  CLK        in   1           clock, all logic on posedge
//  RST        in   1           synchronous reset, active-high
//  A          in   ADDR_WIDTH  access address
//  CEN        in   1           chip enable, active-low
//  GWEN       in   1           global write enable, active-low (0=write, 1=read)
//  WEN        in   DATA_WIDTH  per-bit write enable, active-low
//  D          in   DATA_WIDTH  write data
//  Q          out  DATA_WIDTH  read data
//  Q_VLD      out  1           1-cycle pulse: Q carries data of a newly accepted read
//  INIT_BUSY  out  1           1 while init-clear runs; accesses ignored
// BEHAVIOUR
//  - Reset (RST=1 at posedge): FSM->INIT (INIT_EN=1) or DONE-wait (INIT_EN=0); init counter=0;
//    Q=0, Q_VLD=0, pipe regs=0, held address=0; INIT_BUSY=1 in the cycle after reset. Array
//    contents not reset by RST itself.
//  - FSM: INIT -> READY. INIT: write 0 to entry cnt each cycle, cnt++; on cnt==DEPTH-1 go READY
//    next cycle. INIT lasts exactly DEPTH cycles; INIT_BUSY=1 throughout, 0 in READY.
//    INIT_EN=0: single-cycle pseudo-INIT then READY.
//  - RST asserted mid-INIT: counter restarts at 0, full DEPTH-cycle clear re-runs.
//  - During INIT: CEN/GWEN/WEN/D/A ignored, no write, no Q_VLD; Q holds 0.
//  - Accepted access (READY & !CEN): address latched into held-address reg.
//  - Write (!CEN & !GWEN): for each bit i with WEN[i]=0, mem[A][i] <= D[i]; bits with WEN[i]=1
//    untouched. Write does not update Q, no Q_VLD. WEN all-ones = no-op write.
//  - Read (!CEN & GWEN): READ_PIPE=0: Q=mem[A] after next posedge, Q_VLD=1 that cycle.
//    READ_PIPE=1: data captured into output reg one cycle later; Q/Q_VLD appear 2 cycles after
//    the accepted read. Back-to-back reads sustain one per cycle.
//  - Read of an entry written in the prior cycle returns new data (write completes on its edge).
//  - Idle (CEN=1): Q holds last read data indefinitely; Q_VLD=0; no array access.
//  - Read pipeline in flight when RST asserted: pipe flushed, Q=0, no Q_VLD emitted.
//  - Address beyond DEPTH impossible (A is exactly ADDR_WIDTH bits); no wrap logic needed.
//  - X on CEN/GWEN in READY: sim-only assertion fires; RTL treats as no access.
// TESTING
//  1 Reset, ADDR_WIDTH=4: INIT_BUSY high exactly 16 cycles then 0; read all 16 entries -> Q=0 each.
//  2 Write A=5 D=all-ones WEN=0, then write A=5 D=0 WEN[7:0]=0 only; read A=5 -> Q=all-ones
//    except bits[7:0]=0; Q_VLD one pulse, 1 cycle (READ_PIPE=0) / 2 cycles (READ_PIPE=1) later.
//  3 Reads A=1,2,3 back-to-back, then CEN=1 for 10 cycles -> Q sequence mem[1],mem[2],mem[3],
//    Q stays mem[3] for 10 cycles, Q_VLD=1,1,1,0...
//  4 Write A=7 cycle n, read A=7 cycle n+1 -> new data; write with WEN=all-ones -> entry unchanged.
//  5 RST pulse at cnt=9 during INIT -> INIT_BUSY re-lasts full DEPTH cycles; earlier data
//    (pre-reset writes) all zero afterwards; accesses issued during INIT have no effect.
//  6 RST during read with READ_PIPE=1 -> no Q_VLD after reset, Q=0.

Source files
------------

// File: rtl/ct_f_spsram_param_init.sv
// rtl/ct_f_spsram_param_init.sv - parametrised single-port SRAM model with init-clear, bit-masked writes and read pipeline
module ct_f_spsram_param_init #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 144,
  parameter int READ_PIPE  = 0,
  parameter int INIT_EN    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Q_VLD,
  output logic                  INIT_BUSY
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_WAIT,
    ST_READY
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    busy;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    s1_vld;
  logic [DATA_WIDTH-1:0]   q_r;
  logic                    q_vld_r;

  logic                    ready;
  logic                    acc;
  logic                    wr;
  logic                    rd;
  logic                    rd_fire;
  logic [ADDR_WIDTH-1:0]   rd_addr;

  // Accesses only count in READY; an X on CEN/GWEN never resolves to a true access.
  assign ready = (state == ST_READY);
  assign acc   = ready && (CEN == 1'b0);
  assign wr    = acc && (GWEN == 1'b0);
  assign rd    = acc && (GWEN == 1'b1);

  // With the extra output stage the array is read one cycle later from the held address.
  assign rd_fire = (READ_PIPE != 0) ? s1_vld : rd;
  assign rd_addr = (READ_PIPE != 0) ? addr_q : A;

  // Init-clear sequencer: walks every entry once after reset, then parks in READY.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= (INIT_EN != 0) ? ST_INIT : ST_WAIT;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ST_READY;
            busy  <= 1'b0;
          end
        end
        ST_WAIT: begin
          state <= ST_READY;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_READY;
        end
      endcase
    end
  end

  // Array writes: zero-fill during init, otherwise per-bit masked user writes; contents survive RST.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == ST_INIT) begin
        mem[cnt] <= '0;
      end else if (wr) begin
        mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      end
    end
  end

  // Read path: held address, optional stage-1 valid, output register and valid strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q  <= '0;
      s1_vld  <= 1'b0;
      q_r     <= '0;
      q_vld_r <= 1'b0;
    end else begin
      if (acc) begin
        addr_q <= A;
      end
      if (rd) begin
        s1_vld <= 1'b1;
      end else begin
        s1_vld <= 1'b0;
      end
      if (rd_fire) begin
        q_r     <= mem[rd_addr];
        q_vld_r <= 1'b1;
      end else begin
        q_vld_r <= 1'b0;
      end
    end
  end

  // Control inputs must be resolved whenever the macro can accept an access.
  assert property (@(posedge CLK) disable iff (RST) (state == ST_READY) |-> !$isunknown({CEN, GWEN}));

  assign Q         = q_r;
  assign Q_VLD     = q_vld_r;
  assign INIT_BUSY = busy;

endmodule

// File: tb/tb_ct_f_spsram_param_init.sv
// tb/tb_ct_f_spsram_param_init.sv - scoreboard bench for ct_f_spsram_param_init, READ_PIPE 0 and 1 side by side
module tb_ct_f_spsram_param_init;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] a;
  logic          cen;
  logic          gwen;
  logic [DW-1:0] wen;
  logic [DW-1:0] d;
  logic [DW-1:0] q0, q1;
  logic          q_vld0, q_vld1;
  logic          busy0, busy1;

  exp_t          exp_q [2][$];
  logic [DW-1:0] last [2];
  logic [DW-1:0] mdl [DEPTH];
  int            cyc;
  int            n_assert;
  int            n_fail;

  always #5 clk = ~clk;

  ct_f_spsram_param_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_PIPE(0), .INIT_EN(1)
  ) u_pipe0 (
    .CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
    .Q(q0), .Q_VLD(q_vld0), .INIT_BUSY(busy0)
  );

  ct_f_spsram_param_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_PIPE(1), .INIT_EN(1)
  ) u_pipe1 (
    .CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
    .Q(q1), .Q_VLD(q_vld1), .INIT_BUSY(busy1)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    for (int k = 0; k < 2; k++) begin
      logic          vld;
      logic [DW-1:0] qv;
      logic          exp_vld;
      exp_t          e;
      vld = (k == 0) ? q_vld0 : q_vld1;
      qv  = (k == 0) ? q0 : q1;
      exp_vld = (exp_q[k].size() != 0) && (exp_q[k][0].due == cyc);
      chk($sformatf("q_vld_p%0d_c%0d", k, cyc), {{(DW-1){1'b0}}, vld}, {{(DW-1){1'b0}}, exp_vld});
      if (exp_vld) begin
        e = exp_q[k].pop_front();
        if (vld === 1'b1) chk($sformatf("q_data_p%0d_c%0d", k, cyc), qv, e.data);
        last[k] = e.data;
      end else begin
        chk($sformatf("q_hold_p%0d_c%0d", k, cyc), qv, last[k]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic check_busy(input logic exp, input string tag);
    chk({tag, "_p0"}, {{(DW-1){1'b0}}, busy0}, {{(DW-1){1'b0}}, exp});
    chk({tag, "_p1"}, {{(DW-1){1'b0}}, busy1}, {{(DW-1){1'b0}}, exp});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cen  = 1'b1;
      gwen = 1'b1;
      step();
    end
  endtask

  task automatic wr_op(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [DW-1:0] mask);
    a    = addr;
    cen  = 1'b0;
    gwen = 1'b0;
    d    = data;
    wen  = mask;
    mdl[addr] = (mdl[addr] & mask) | (data & ~mask);
    step();
  endtask

  task automatic rd_op(input logic [AW-1:0] addr);
    exp_t e;
    a    = addr;
    cen  = 1'b0;
    gwen = 1'b1;
    e.data = mdl[addr];
    e.due  = cyc + 1;
    exp_q[0].push_back(e);
    e.due  = cyc + 2;
    exp_q[1].push_back(e);
    step();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    cen  = 1'b1;
    gwen = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    last[0] = '0;
    last[1] = '0;
    step();
    check_busy(1'b1, "busy_after_rst");
    rst = 1'b0;
  endtask

  // Accesses driven during init must neither write nor produce a read strobe.
  task automatic init_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      a    = i[AW-1:0];
      cen  = 1'b0;
      gwen = i[0];
      d    = '1;
      wen  = '0;
      step();
      check_busy(1'b1, $sformatf("busy_init_%0d", i));
    end
  endtask

  task automatic finish_init();
    init_cycles(DEPTH - 1);
    cen  = 1'b1;
    gwen = 1'b1;
    step();
    check_busy(1'b0, "busy_done");
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

  initial begin
    logic [DW-1:0] rv;
    logic [DW-1:0] rm;
    logic [AW-1:0] ra;
    rst = 1'b1; a = '0; cen = 1'b1; gwen = 1'b1; wen = '1; d = '0;
    cyc = 0; n_assert = 0; n_fail = 0;
    last[0] = '0; last[1] = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

    // Reset and full init, then every entry reads back zero.
    do_reset();
    finish_init();
    for (int i = 0; i < DEPTH; i++) rd_op(i[AW-1:0]);
    idle(3);

    // Full write then low-byte-only masked write.
    wr_op(4'd5, 16'hFFFF, 16'h0000);
    wr_op(4'd5, 16'h0000, 16'hFF00);
    rd_op(4'd5);
    idle(3);

    // Back-to-back reads followed by a long idle: Q must hold the last read.
    wr_op(4'd1, 16'hA1A1, 16'h0000);
    wr_op(4'd2, 16'hB2B2, 16'h0000);
    wr_op(4'd3, 16'hC3C3, 16'h0000);
    rd_op(4'd1);
    rd_op(4'd2);
    rd_op(4'd3);
    idle(10);

    // Read directly after write, and an all-ones mask write leaves the entry alone.
    wr_op(4'd7, 16'h1234, 16'h0000);
    rd_op(4'd7);
    wr_op(4'd7, 16'hFFFF, 16'hFFFF);
    rd_op(4'd7);
    idle(2);

    // Mixed random traffic against the bench model.
    for (int i = 0; i < 24; i++) begin
      ra = AW'($urandom_range(0, DEPTH - 1));
      rv = DW'($urandom);
      rm = DW'($urandom);
      if ($urandom_range(0, 1) == 0) wr_op(ra, rv, rm);
      else rd_op(ra);
    end
    idle(3);

    // Reset when the clear counter has reached 9: the full clear runs again.
    do_reset();
    init_cycles(9);
    do_reset();
    finish_init();
    for (int i = 0; i < DEPTH; i++) rd_op(i[AW-1:0]);
    idle(3);

    // Reset while the two-stage read is in flight: no strobe, Q cleared.
    wr_op(4'd3, 16'h5A5A, 16'h0000);
    rd_op(4'd3);
    do_reset();
    finish_init();
    rd_op(4'd3);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
